// File: rtl/ram_arbiter_if.sv
// ram_arbiter_if -- bundle of the two requester ports and the RAM port that
// ram_arbiter multiplexes.
//   slave  modport : arbiter view (requests in, grants/read data out, RAM out)
//   master modport : surroundings view (requesters + RAM model)
// Signals:
//   a_req/a_addr -> a_gnt/a_rvalid/a_rdata          port A, read-only fetch
//   b_req/b_we/b_addr/b_wdata -> b_gnt/b_rvalid/b_rdata  port B, read/write
//   ram_addr/ram_we/ram_wdata -> ram_rdata          synchronous RAM, 1-cycle read
// Optional: ARB_LOCK_EN adds b_lock (port B bus lock request).
interface ram_arbiter_if #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8
);
  logic              a_req;
  logic [ADDR_W-1:0] a_addr;
  logic              a_gnt;
  logic              a_rvalid;
  logic [DATA_W-1:0] a_rdata;

  logic              b_req;
  logic              b_we;
  logic [ADDR_W-1:0] b_addr;
  logic [DATA_W-1:0] b_wdata;
  logic              b_gnt;
  logic              b_rvalid;
  logic [DATA_W-1:0] b_rdata;
`ifdef ARB_LOCK_EN
  logic              b_lock;
`endif

  logic [ADDR_W-1:0] ram_addr;
  logic              ram_we;
  logic [DATA_W-1:0] ram_wdata;
  logic [DATA_W-1:0] ram_rdata;

  modport slave (
`ifdef ARB_LOCK_EN
    input  b_lock,
`endif
    input  a_req, a_addr,
    output a_gnt, a_rvalid, a_rdata,
    input  b_req, b_we, b_addr, b_wdata,
    output b_gnt, b_rvalid, b_rdata,
    output ram_addr, ram_we, ram_wdata,
    input  ram_rdata
  );

  modport master (
`ifdef ARB_LOCK_EN
    output b_lock,
`endif
    output a_req, a_addr,
    input  a_gnt, a_rvalid, a_rdata,
    output b_req, b_we, b_addr, b_wdata,
    input  b_gnt, b_rvalid, b_rdata,
    input  ram_addr, ram_we, ram_wdata,
    output ram_rdata
  );
endinterface

// File: rtl/ram_arbiter.sv
// ram_arbiter -- shares one synchronous RAM port between the CPU fetch port
// (A, read-only) and the loader/debug port (B, read/write).
//
// Ports:
//   clk  rising-edge clock (CPU divided clock)
//   rst  asynchronous, active-low reset
//   bus  ram_arbiter_if.slave: A/B request ports and RAM port
//
// Operation: registered req/gnt. At most one grant per cycle; a port whose
// gnt is currently high is masked, so a lone requester is served every other
// cycle and two requesters alternate A,B,A,B. The winner's address (and B's
// write strobe/data) is registered onto the RAM port in the grant cycle; the
// RAM samples it at the next edge, where the matching rvalid is raised and
// ram_rdata is passed straight through to the requester.
//
// Optional feature (macro ARB_LOCK_EN): input b_lock. While b_lock=1 and the
// last grant went to B, port A is ineligible, so B keeps the RAM across its
// masked cycles. The lock has no effect until B has been granted once.
module ram_arbiter #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8
) (
  input  logic          clk,
  input  logic          rst,
  ram_arbiter_if.slave  bus
);

  // Last-grant state: doubles as the registered gnt outputs.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GNT_A = 2'd1,
    GNT_B = 2'd2
  } state_t;

  state_t            st, st_nxt;
  logic              ptr_b, ptr_b_nxt;      // 1 = B preferred on a tie
  logic [ADDR_W-1:0] ram_addr_q, ram_addr_nxt;
  logic              ram_we_q, ram_we_nxt;
  logic [DATA_W-1:0] ram_wdata_q, ram_wdata_nxt;
  logic              a_rvalid_q, b_rvalid_q;

  logic a_elig, b_elig, a_win, b_win;
  logic a_lock_blk;                         // A held off by a B lock

`ifdef ARB_LOCK_EN
  // Tracks whether the most recent grant went to B. Only grants move it, so
  // it stays set through B's masked cycles and the lock survives them.
  logic last_b, last_b_nxt;

  always_comb begin
    last_b_nxt = last_b;
    if (a_win)      last_b_nxt = 1'b0;
    else if (b_win) last_b_nxt = 1'b1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) last_b <= 1'b0;
    else      last_b <= last_b_nxt;
  end

  assign a_lock_blk = bus.b_lock & last_b;
`else
  assign a_lock_blk = 1'b0;
`endif

  // Next-state / next-output logic
  always_comb begin
    st_nxt        = IDLE;
    ptr_b_nxt     = ptr_b;
    ram_addr_nxt  = ram_addr_q;
    ram_we_nxt    = 1'b0;
    ram_wdata_nxt = ram_wdata_q;

    // A request seen while its own gnt is high is the old, already accepted
    // request; ignore it so the same port cannot be granted twice in a row.
    a_elig = bus.a_req & (st != GNT_A) & ~a_lock_blk;
    b_elig = bus.b_req & (st != GNT_B);
    a_win  = a_elig & (~b_elig | ~ptr_b);
    b_win  = b_elig & ~a_win;

    if (a_win) begin
      st_nxt       = GNT_A;
      ptr_b_nxt    = 1'b1;
      ram_addr_nxt = bus.a_addr;
    end else if (b_win) begin
      st_nxt        = GNT_B;
      ptr_b_nxt     = 1'b0;
      ram_addr_nxt  = bus.b_addr;
      ram_we_nxt    = bus.b_we;
      ram_wdata_nxt = bus.b_wdata;
    end
  end

  // State and registered outputs
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      st          <= IDLE;
      ptr_b       <= 1'b0;
      ram_addr_q  <= '0;
      ram_we_q    <= 1'b0;
      ram_wdata_q <= '0;
      a_rvalid_q  <= 1'b0;
      b_rvalid_q  <= 1'b0;
    end else begin
      st          <= st_nxt;
      ptr_b       <= ptr_b_nxt;
      ram_addr_q  <= ram_addr_nxt;
      ram_we_q    <= ram_we_nxt;
      ram_wdata_q <= ram_wdata_nxt;
      // The RAM samples the granted address at this edge; data follows now.
      a_rvalid_q  <= (st == GNT_A);
      b_rvalid_q  <= (st == GNT_B) & ~ram_we_q;
    end
  end

  assign bus.a_gnt     = (st == GNT_A);
  assign bus.b_gnt     = (st == GNT_B);
  assign bus.a_rvalid  = a_rvalid_q;
  assign bus.b_rvalid  = b_rvalid_q;
  assign bus.a_rdata   = bus.ram_rdata;
  assign bus.b_rdata   = bus.ram_rdata;
  assign bus.ram_addr  = ram_addr_q;
  assign bus.ram_we    = ram_we_q;
  assign bus.ram_wdata = ram_wdata_q;

`ifndef SYNTHESIS
  // Requester contract: a request that was eligible but lost must still be
  // present at the next edge. The arbiter has no recovery for a withdrawn one.
  logic a_pend, b_pend;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      a_pend <= 1'b0;
      b_pend <= 1'b0;
    end else begin
      a_pend <= a_elig & ~a_win;
      b_pend <= b_elig & ~b_win;
    end
  end

  a_req_held: assert property (@(posedge clk) disable iff (!rst) a_pend |-> bus.a_req)
    else $error("ram_arbiter: a_req withdrawn before a_gnt");
  b_req_held: assert property (@(posedge clk) disable iff (!rst) b_pend |-> bus.b_req)
    else $error("ram_arbiter: b_req withdrawn before b_gnt");
`endif

endmodule

// File: tb/tb_ram_arbiter.sv
// tb_ram_arbiter -- directed, table-driven bench for ram_arbiter with a
// behavioural 256x8 synchronous RAM (1-cycle read latency) on the RAM port.
// Inputs change 1 time unit after a rising edge; outputs are checked there.
module tb_ram_arbiter;
  localparam int AW = 8;
  localparam int DW = 8;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  ram_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus();
  ram_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (.clk(clk), .rst(rst), .bus(bus));

  // RAM model; known contents are (re)loaded while reset is held.
  logic [DW-1:0] mem [0:255];
  always @(posedge clk) begin
    if (!rst) begin
      mem[8'h05] <= 8'h3C;
      mem[8'h0A] <= 8'h55;
      mem[8'hFF] <= 8'hA5;
    end else if (bus.ram_we) begin
      mem[bus.ram_addr] <= bus.ram_wdata;
    end
    bus.ram_rdata <= mem[bus.ram_addr];
  end

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // {a_gnt, b_gnt, a_rvalid, b_rvalid, ram_we, ram_addr, ram_wdata}
  function automatic logic [20:0] outs();
    return {bus.a_gnt, bus.b_gnt, bus.a_rvalid, bus.b_rvalid, bus.ram_we,
            bus.ram_addr, bus.ram_wdata};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic ar, input logic [7:0] aa, input logic br,
                       input logic bw, input logic [7:0] ba, input logic [7:0] bd);
    bus.a_req = ar; bus.a_addr = aa;
    bus.b_req = br; bus.b_we = bw; bus.b_addr = ba; bus.b_wdata = bd;
  endtask

  // Check outputs; read data compared only when an rvalid is expected.
  task automatic chk_all(input string name, input logic [4:0] fl, input logic [7:0] ra,
                         input logic [7:0] rw, input logic [7:0] rd);
    chk(name, {11'd0, outs()}, {11'd0, fl, ra, rw});
    if (fl[2]) chk({name, "_ardata"}, {24'd0, bus.a_rdata}, {24'd0, rd});
    if (fl[1]) chk({name, "_brdata"}, {24'd0, bus.b_rdata}, {24'd0, rd});
  endtask

  typedef struct {
    logic       ar;
    logic [7:0] aa;
    logic       br;
    logic       bw;
    logic [7:0] ba;
    logic [7:0] bd;
    logic [4:0] fl;   // expected {a_gnt, b_gnt, a_rvalid, b_rvalid, ram_we}
    logic [7:0] ra;   // expected ram_addr
    logic [7:0] rw;   // expected ram_wdata
    logic [7:0] rd;   // expected read data when an rvalid is set
  } vec_t;

  function automatic vec_t mk(logic ar, logic [7:0] aa, logic br, logic bw, logic [7:0] ba,
                              logic [7:0] bd, logic [4:0] fl, logic [7:0] ra,
                              logic [7:0] rw, logic [7:0] rd);
    vec_t v;
    v.ar = ar; v.aa = aa; v.br = br; v.bw = bw; v.ba = ba; v.bd = bd;
    v.fl = fl; v.ra = ra; v.rw = rw; v.rd = rd;
    return v;
  endfunction

  vec_t vecs[$];

  initial begin
`ifdef ARB_LOCK_EN
    bus.b_lock = 1'b0;
`endif
    // Contention from reset release: A,B,A,B... rvalid one cycle after gnt.
    for (int i = 0; i < 8; i++) begin
      if (i % 2 == 0)
        vecs.push_back(mk(1, 8'h05, 1, 0, 8'h0A, 8'h77, (i == 0) ? 5'b10000 : 5'b10010,
                          8'h05, (i == 0) ? 8'h00 : 8'h77, 8'h55));
      else
        vecs.push_back(mk(1, 8'h05, 1, 0, 8'h0A, 8'h77, 5'b01100, 8'h0A, 8'h77, 8'h3C));
    end
    vecs.push_back(mk(0, 8'h00, 0, 0, 8'h0A, 8'h77, 5'b00010, 8'h0A, 8'h77, 8'h55));
    vecs.push_back(mk(0, 8'h00, 0, 0, 8'h00, 8'h00, 5'b00000, 8'h0A, 8'h77, 8'h00));
    // A-only: granted every other cycle while held; ram_wdata holds.
    vecs.push_back(mk(1, 8'h05, 0, 0, 8'h00, 8'h00, 5'b10000, 8'h05, 8'h77, 8'h00));
    vecs.push_back(mk(1, 8'h05, 0, 0, 8'h00, 8'h00, 5'b00100, 8'h05, 8'h77, 8'h3C));
    vecs.push_back(mk(1, 8'h05, 0, 0, 8'h00, 8'h00, 5'b10000, 8'h05, 8'h77, 8'h00));
    vecs.push_back(mk(0, 8'h00, 0, 0, 8'h00, 8'h00, 5'b00100, 8'h05, 8'h77, 8'h3C));
    // B write: one ram_we pulse, no b_rvalid; then read it back.
    vecs.push_back(mk(0, 8'h00, 1, 1, 8'h0A, 8'h81, 5'b01001, 8'h0A, 8'h81, 8'h00));
    vecs.push_back(mk(0, 8'h00, 0, 0, 8'h0A, 8'h81, 5'b00000, 8'h0A, 8'h81, 8'h00));
    vecs.push_back(mk(0, 8'h00, 1, 0, 8'h0A, 8'h81, 5'b01000, 8'h0A, 8'h81, 8'h00));
    vecs.push_back(mk(0, 8'h00, 0, 0, 8'h00, 8'h00, 5'b00010, 8'h0A, 8'h81, 8'h81));
    // Top of the address range passes through unmodified.
    vecs.push_back(mk(1, 8'hFF, 0, 0, 8'h00, 8'h00, 5'b10000, 8'hFF, 8'h81, 8'h00));
    vecs.push_back(mk(0, 8'h00, 0, 0, 8'h00, 8'h00, 5'b00100, 8'hFF, 8'h81, 8'hA5));

    // Reset held with both requests up: everything quiet.
    drive(1, 8'h05, 1, 0, 8'h0A, 8'h77);
    tick();
    tick();
    chk("reset_hold", {11'd0, outs()}, 32'd0);
    rst = 1'b1;

    foreach (vecs[i]) begin
      drive(vecs[i].ar, vecs[i].aa, vecs[i].br, vecs[i].bw, vecs[i].ba, vecs[i].bd);
      tick();
      chk_all($sformatf("vec%0d", i), vecs[i].fl, vecs[i].ra, vecs[i].rw, vecs[i].rd);
    end

    // Reset during an A grant: no rvalid afterwards, pointer back to A.
    drive(1, 8'h05, 0, 0, 8'h00, 8'h00);
    tick();
    chk_all("mid_gnt", 5'b10000, 8'h05, 8'h81, 8'h00);
    #2 rst = 1'b0;
    #1 chk("mid_async", {11'd0, outs()}, 32'd0);
    drive(0, 8'h00, 0, 0, 8'h00, 8'h00);
    tick();
    chk("mid_inrst", {11'd0, outs()}, 32'd0);
    rst = 1'b1;
    tick();
    chk("mid_norv", {11'd0, outs()}, 32'd0);
    drive(1, 8'h05, 1, 0, 8'h0A, 8'h00);
    tick();
    chk_all("mid_ptr", 5'b10000, 8'h05, 8'h00, 8'h00);
    drive(0, 8'h00, 1, 0, 8'h0A, 8'h00);
    tick();
    chk_all("mid_b", 5'b01100, 8'h0A, 8'h00, 8'h3C);
    drive(0, 8'h00, 0, 0, 8'h00, 8'h00);
    tick();
    chk_all("mid_brv", 5'b00010, 8'h0A, 8'h00, 8'h55);
    tick();
    chk_all("mid_idle", 5'b00000, 8'h0A, 8'h00, 8'h00);

`ifdef ARB_LOCK_EN
    // B takes the lock; A is held off for as long as b_lock stays high.
    bus.b_lock = 1'b1;
    drive(0, 8'h00, 1, 0, 8'h0A, 8'h00);
    tick();
    chk_all("lock_b0", 5'b01000, 8'h0A, 8'h00, 8'h00);
    drive(1, 8'h05, 1, 0, 8'h0A, 8'h00);
    for (int i = 0; i < 6; i++) begin
      tick();
      chk_all($sformatf("lock%0d", i), (i % 2 == 0) ? 5'b00010 : 5'b01000,
              8'h0A, 8'h00, 8'h55);
    end
    bus.b_lock = 1'b0;
    tick();
    chk_all("unlock_a", 5'b10010, 8'h05, 8'h00, 8'h55);
    drive(0, 8'h00, 0, 0, 8'h00, 8'h00);
    tick();
    chk_all("unlock_rv", 5'b00100, 8'h05, 8'h00, 8'h3C);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/ram_arbiter.md
Name: ram_arbiter

Overview:
- Shares the single synchronous program/data RAM port between two requesters.
  - Port A: CPU instruction/data fetch, read-only.
  - Port B: program loader / debug access, read or write.
- Sits between cpu, loader and ram in the top level, and runs on the same divided clock as the CPU.
- Uses registered req/gnt arbitration, round-robin when both ports request, one RAM access per cycle.

Parameters:
- ADDR_W, 8, RAM address width.
- DATA_W, 8, RAM data width.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  reset, asynchronous, active-low.
- a_req  input  1  port A read request; held with a_addr stable until a_gnt is seen.
- a_addr  input  ADDR_W  port A read address.
- a_gnt  output  1  port A request accepted this cycle.
- a_rvalid  output  1  a_rdata valid this cycle.
- a_rdata  output  DATA_W  port A read data.
- b_req  input  1  port B request; held with b_addr, b_we and b_wdata stable until b_gnt.
- b_we  input  1  port B write (1) or read (0).
- b_addr  input  ADDR_W  port B address.
- b_wdata  input  DATA_W  port B write data.
- b_gnt  output  1  port B request accepted this cycle.
- b_rvalid  output  1  b_rdata valid this cycle; reads only.
- b_rdata  output  DATA_W  port B read data.
- ram_addr  output  ADDR_W  RAM address, used for both read and write.
- ram_we  output  1  RAM write enable.
- ram_wdata  output  DATA_W  RAM write data.
- ram_rdata  input  DATA_W  RAM read data, registered in the RAM with 1-cycle latency.

Behaviour:
- Reset, asynchronous while rst=0:
  - a_gnt, b_gnt, a_rvalid, b_rvalid, ram_we all 0.
  - ram_addr and ram_wdata 0.
  - Round-robin pointer set to "A preferred".
  - Reset mid-transaction drops the transaction: no rvalid follows, and any pending write is not issued.
- Arbitration at each rising edge k:
  - A port whose gnt is currently 1 has its req ignored, i.e. treated as 0.
  - Eligible set = ports with req=1 after masking.
  - Exactly one eligible port: that port wins.
  - Both eligible: the pointer decides.
  - After any grant, the pointer prefers the other port.
  - No eligible port: both gnt 0, ram_we 0, ram_addr holds its last value, pointer unchanged.
- Grant cycle, registered at edge k:
  - Winner's gnt=1 for exactly one cycle.
  - ram_addr = winner's address.
  - ram_we = b_we if B won, else 0.
  - ram_wdata = b_wdata if B won; otherwise holds its last value.
- Read return:
  - At edge k+1 the RAM samples the address.
  - Arbiter sets the winner's rvalid=1 for exactly one cycle, registered at edge k+1.
  - x_rdata = ram_rdata, combinational pass-through. Value is only meaningful while x_rvalid=1.
  - B write: b_rvalid stays 0, and ram_we is a single-cycle pulse.
- Throughput:
  - One grant per cycle at most.
  - A single port requesting continuously is granted every other cycle.
  - Both ports requesting continuously alternate every cycle: A,B,A,B…
  - A's rvalid and B's gnt may be high in the same cycle.
- Requester contract:
  - Once req is raised, it must stay high with address and data stable until gnt is observed.
  - Requester drops req or presents a new request at the edge ending the gnt cycle.
  - Dropping req before gnt is illegal. Checked by assertion only under simulation; no RTL recovery.
- Address wrap: none. Addresses pass through unmodified, full ADDR_W range.
- State machine:
  - 2-bit last-grant state IDLE/GNT_A/GNT_B, plus a 1-bit pointer.
  - IDLE→GNT_x on a win.
  - GNT_x→GNT_y or IDLE at the next edge per the rules above.
  - GNT_x→GNT_x is impossible, because the granted port is masked.

Optional Feature:
- Macro: ARB_LOCK_EN.
- Defined:
  - Adds input b_lock (1 bit).
  - While b_lock=1 and the last grant went to B, port A is ineligible.
  - B keeps ownership across its masked cycles: B is granted every other cycle and A is never granted.
  - Lock releases at the first edge with b_lock=0.
  - b_lock is ignored if B has not yet been granted.
- Not defined: no b_lock port; plain round-robin as above.

Test Plan:
- Reset check: hold rst=0 with a_req=b_req=1 → all gnt/rvalid/ram_we 0. Release rst → first grant goes to A.
- A-only read: a_req=1, a_addr=0x05, ram holds 0x3C at 0x05 → a_gnt at cycle k, ram_addr=0x05 at cycle k, a_rvalid=1 with a_rdata=0x3C at cycle k+1. Next grant no earlier than cycle k+2.
- B write then read: b_we=1, b_addr=0x0A, b_wdata=0x81 → single ram_we pulse with ram_addr=0x0A, ram_wdata=0x81, no b_rvalid. Then B read of 0x0A → b_rvalid with b_rdata=0x81.
- Contention: a_req=b_req=1 held continuously for 8 cycles after reset → grant sequence A,B,A,B,A,B,A,B. Each rvalid occurs exactly 1 cycle after its gnt, and no cycle has both gnts high.
- Reset mid-operation: assert rst=0 in the cycle a_gnt=1 → no a_rvalid afterwards, pointer returns to "A preferred".
- ARB_LOCK_EN: B granted with b_lock=1, a_req=1 for 6 cycles → only B is granted, on alternate cycles. Drop b_lock → A granted at the next eligible edge.
